pipeline_stall_ctrl: RTL and testbench

- Control-side counterpart to the pipeline stage shift registers. Those registers only hold and shift; this block decides every cycle whether they shift, hold the front end, take a bubble, or flush.
- Tracks outstanding instruction and data memory responses across stall cycles.
- Detects load-use hazards and applies branch-taken flushes.
- Keeps saturating performance counters.
- Sits between the memory interfaces, the ID/EX stage fields and the shift-register load/mux controls.

---
 rtl/pipeline_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the stage shift registers.
// Tracks memory responses, load-use hazards and perf counters.
module pipeline_stall_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_req,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic [REG_W-1:0]     id_rs1,
  input  logic [REG_W-1:0]     id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_W-1:0]     ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_br_taken,
  output logic                 load_pc,
  output logic                 load_pipe,
  output logic                 hold_front,
  output logic                 bubble_ex,
  output logic                 flush_front,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] bubble_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] IDONE = 2'd1;
  localparam logic [1:0] DDONE = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       i_ok;
  logic       d_ok;
  logic       advance;
  logic       lu;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       go;
  logic       sel_br;
  logic       sel_bub;
  logic       sel_run;

  assign state = state_q;

  assign i_ok    = !imem_req | imem_resp | (state_q == IDONE);
  assign d_ok    = !dmem_req | dmem_resp | (state_q == DDONE);
  assign advance = i_ok & d_ok;

  assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);
  assign lu      = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

  // One-hot select terms keep the decoder below truly unique
  assign go      = reset & advance;
  assign sel_br  = go & ex_br_taken;
  assign sel_bub = go & !ex_br_taken & lu;
  assign sel_run = go & !ex_br_taken & !lu;

  always_comb begin
    load_pc     = 1'b0;
    load_pipe   = 1'b0;
    hold_front  = 1'b0;
    bubble_ex   = 1'b0;
    flush_front = 1'b0;
    unique case (1'b1)
      sel_br: begin
        load_pipe   = 1'b1;
        load_pc     = 1'b1;
        flush_front = 1'b1;
      end
      sel_bub: begin
        load_pipe  = 1'b1;
        hold_front = 1'b1;
        bubble_ex  = 1'b1;
      end
      sel_run: begin
        load_pipe = 1'b1;
        load_pc   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (imem_req & imem_resp)
            state_d = IDONE;
          else if (dmem_req & dmem_resp)
            state_d = DDONE;
        end
        IDONE:   state_d = IDONE;
        DDONE:   state_d = DDONE;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters stick at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (!advance && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (bubble_ex && bubble_count != '1)
        bubble_count <= bubble_count + CNT_WIDTH'(1);
      if (flush_front && flush_count != '1)
        flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: response-tracking model checked
// every cycle, plus directed vectors with literal expectations.
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;
  localparam int RW = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req, imem_resp, dmem_req, dmem_resp;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken;
  logic          load_pc, load_pipe, hold_front, bubble_ex, flush_front;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles, bubble_count, flush_count;

  int vectors = 0;
  int errors  = 0;
  bit run_chk = 1'b0;

  bit i_got, d_got;
  int m_stall, m_bub, m_flush;

  pipeline_stall_ctrl #(.CNT_WIDTH(CW), .REG_W(RW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_br_taken(ex_br_taken),
    .load_pc(load_pc), .load_pipe(load_pipe),
    .hold_front(hold_front), .bubble_ex(bubble_ex),
    .flush_front(flush_front), .state(state),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_adv();
    bit iok, dok;
    iok = !imem_req || imem_resp || i_got;
    dok = !dmem_req || dmem_resp || d_got;
    return iok && dok;
  endfunction

  function automatic bit m_lu();
    bit h1, h2;
    h1 = id_uses_rs1 && id_rs1 == ex_rd;
    h2 = id_uses_rs2 && id_rs2 == ex_rd;
    return ex_mem_read && ex_rd != 0 && (h1 || h2);
  endfunction

  // {load_pc, load_pipe, hold_front, bubble_ex, flush_front}
  function automatic logic [4:0] m_ctl();
    if (!reset || !m_adv()) return 5'b00000;
    if (ex_br_taken) return 5'b11001;
    if (m_lu()) return 5'b01110;
    return 5'b11000;
  endfunction

  function automatic int m_state();
    if (i_got) return 1;
    if (d_got) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_got = 0; d_got = 0;
      m_stall = 0; m_bub = 0; m_flush = 0;
    end else begin
      logic [4:0] c;
      c = m_ctl();
      if (!m_adv() && m_stall < SAT) m_stall++;
      if (c[1] && m_bub < SAT) m_bub++;
      if (c[0] && m_flush < SAT) m_flush++;
      if (m_adv()) begin
        i_got = 0; d_got = 0;
      end else if (!i_got && !d_got) begin
        if (imem_req && imem_resp) i_got = 1;
        else if (dmem_req && dmem_resp) d_got = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      logic [4:0] e;
      e = m_ctl();
      chk("load_pc", int'(load_pc), int'(e[4]));
      chk("load_pipe", int'(load_pipe), int'(e[3]));
      chk("hold_front", int'(hold_front), int'(e[2]));
      chk("bubble_ex", int'(bubble_ex), int'(e[1]));
      chk("flush_front", int'(flush_front), int'(e[0]));
      chk("state", int'(state), m_state());
      chk("stall_cycles", int'(stall_cycles), m_stall);
      chk("bubble_count", int'(bubble_count), m_bub);
      chk("flush_count", int'(flush_count), m_flush);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_br_taken = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    #1;
    reset = 0;
    run_chk = 1;
    imem_req = 1; imem_resp = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst load_pipe", int'(load_pipe), 0);
      chk("rst load_pc", int'(load_pc), 0);
      chk("rst state", int'(state), 0);
      chk("rst stall", int'(stall_cycles), 0);
      tick();
    end
    reset = 1;
    @(negedge clk);
    chk("rel load_pipe", int'(load_pipe), 1);
    chk("rel load_pc", int'(load_pc), 1);
    tick();

    // DDONE path: dmem at cycle 1, imem at cycle 4
    idle();
    do_reset();
    imem_req = 1; dmem_req = 1;
    tick();
    dmem_resp = 1;
    tick();
    dmem_resp = 0;
    @(negedge clk);
    chk("ddone state", int'(state), 2);
    tick();
    tick();
    imem_resp = 1;
    @(negedge clk);
    chk("ddone c4 state", int'(state), 2);
    chk("ddone c4 load_pipe", int'(load_pipe), 1);
    tick();
    idle();
    @(negedge clk);
    chk("ddone exit state", int'(state), 0);
    chk("ddone stall", int'(stall_cycles), 4);
    tick();

    // Load-use via rs2
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    id_rs1 = 5; id_uses_rs1 = 0;
    @(negedge clk);
    chk("lu hold_front", int'(hold_front), 1);
    chk("lu bubble_ex", int'(bubble_ex), 1);
    chk("lu load_pc", int'(load_pc), 0);
    tick();
    ex_rd = 0; id_rs2 = 0;
    @(negedge clk);
    chk("lu bubble_count", int'(bubble_count), 1);
    chk("rd0 bubble_ex", int'(bubble_ex), 0);
    chk("rd0 load_pc", int'(load_pc), 1);
    tick();
    // rs1 match but unused
    ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0; id_rs2 = 3;
    @(negedge clk);
    chk("rs1 unused bubble", int'(bubble_ex), 0);
    tick();
    id_uses_rs1 = 1;
    @(negedge clk);
    chk("rs1 bubble", int'(bubble_ex), 1);
    tick();

    // Branch beats load-use
    ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1; ex_br_taken = 1;
    @(negedge clk);
    chk("br flush_front", int'(flush_front), 1);
    chk("br load_pc", int'(load_pc), 1);
    chk("br bubble_ex", int'(bubble_ex), 0);
    chk("br hold_front", int'(hold_front), 0);
    tick();
    idle();
    @(negedge clk);
    chk("br flush_count", int'(flush_count), 1);
    chk("br bubble_count", int'(bubble_count), 2);
    tick();

    // Branch during stall stays pending
    dmem_req = 1; ex_br_taken = 1;
    @(negedge clk);
    chk("stall br flush", int'(flush_front), 0);
    tick();
    idle();

    // Both responses together, and a response with req low
    imem_req = 1; imem_resp = 1; dmem_req = 1; dmem_resp = 1;
    @(negedge clk);
    chk("both load_pipe", int'(load_pipe), 1);
    tick();
    imem_req = 0; imem_resp = 1; dmem_req = 1; dmem_resp = 0;
    tick();
    @(negedge clk);
    chk("noreq state", int'(state), 0);
    tick();
    idle();

    // Reset discards a latched imem response
    imem_req = 1; dmem_req = 1; imem_resp = 1;
    tick();
    imem_resp = 0;
    @(negedge clk);
    chk("idone state", int'(state), 1);
    tick();
    reset = 0;
    @(negedge clk);
    chk("idone rst state", int'(state), 0);
    tick();
    reset = 1; dmem_resp = 1;
    @(negedge clk);
    chk("post rst dmem only", int'(load_pipe), 0);
    tick();
    dmem_resp = 0; imem_resp = 1;
    @(negedge clk);
    chk("post rst imem", int'(load_pipe), 1);
    tick();
    idle();

    // Saturation of the stall counter
    do_reset();
    dmem_req = 1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("sat stall", int'(stall_cycles), SAT);
    chk("sat load_pipe", int'(load_pipe), 0);
    tick();
    idle();
    tick();

    run_chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
